// File: rtl/processor.sv
// 8-bit multi-cycle accumulator-style CPU: four registers and a 256x8 unified memory.
// Each instruction takes FETCH, DECODE and EXEC, one clock edge apiece.

module processor_mem (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);
  logic [7:0] mem [0:255];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];
endmodule

module processor (
  input logic rst,
  input logic clk
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DECODE = 2'd2, EXEC = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  opnd_q, opnd_d;
  logic [7:0]  r_q [4];
  logic [7:0]  r_d [4];
  logic        zf_q, zf_d;
  logic        of_q, of_d;

  logic [3:0]  op;
  logic [1:0]  rd, rs;
  logic [7:0]  a, b;
  logic        two_byte;
  logic [8:0]  sum;
  logic [15:0] prod;
  logic [7:0]  alu_res;
  logic        alu_of;

  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  assign op = ir_q[7:4];
  assign rd = ir_q[3:2];
  assign rs = ir_q[1:0];
  assign a  = r_q[rd];
  assign b  = r_q[rs];
  // writei (1100) and regid (1000) use a register as the address, so they stay single-byte
  assign two_byte = op[3] && (op != 4'b1000) && (op != 4'b1100);

  processor_mem mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    prod    = {8'h00, a} * {8'h00, b};
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      4'h0: begin alu_res = sum[7:0]; alu_of = sum[8]; end
      4'h1: begin alu_res = a - b;    alu_of = (b > a); end
      4'h2: alu_res = a & b;
      4'h3: alu_res = ~b;
      4'h4: alu_res = a | b;
      4'h5: begin alu_res = prod[7:0]; alu_of = |prod[15:8]; end
      default: ;
    endcase
  end

  always_comb begin
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = a;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    zf_d      = zf_q;
    of_d      = of_q;
    for (int i = 0; i < 4; i++) r_d[i] = r_q[i];

    case (state_q)
      FETCH: begin
        ir_d = mem_rdata;
        pc_d = pc_q + 8'd1;
      end
      DECODE: begin
        if (two_byte) begin
          opnd_d = mem_rdata;
          pc_d   = pc_q + 8'd1;
        end
      end
      EXEC: begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            r_d[rd] = alu_res;
            zf_d    = (alu_res == 8'h00);
            of_d    = alu_of;
          end
          4'h7: r_d[rd] = b;
          4'h8: begin
            mem_addr = b;
            r_d[rd]  = mem_rdata;
          end
          4'h9: begin
            mem_addr = opnd_q;
            r_d[rd]  = mem_rdata;
          end
          4'hA: r_d[rd] = opnd_q;
          4'hB: begin
            mem_addr = opnd_q;
            mem_we   = 1'b1;
          end
          4'hC: begin
            mem_addr = b;
            mem_we   = 1'b1;
          end
          4'hD: pc_d = opnd_q;
          4'hE: if (zf_q) pc_d = opnd_q;
          4'hF: if (of_q) pc_d = opnd_q;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      opnd_q <= '0;
      zf_q   <= 1'b0;
      of_q   <= 1'b0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      opnd_q <= opnd_d;
      zf_q   <= zf_d;
      of_q   <= of_d;
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
    end
  end
endmodule

// File: tb/tb_processor.sv
// Program-level bench for processor: loads memory images, runs them and checks
// architectural state at chosen instruction counts against a queue of expectations.

module tb_processor;
  logic rst;
  logic clk;

  processor dut (
    .rst (rst),
    .clk (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_REG = 0, K_PC = 1, K_ZF = 2, K_OF = 3, K_MEM = 4, K_IR = 5, K_ST = 6;

  typedef struct {
    int         at;
    int         kind;
    int         idx;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] prog [$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void expect_at(int at, int kind, int idx, logic [7:0] v, string name);
    exp_t e;
    e.at = at; e.kind = kind; e.idx = idx; e.exp = v; e.name = name;
    sb.push_back(e);
  endfunction

  function automatic logic [7:0] observe(int kind, int idx);
    case (kind)
      K_REG:   return dut.r_q[idx];
      K_PC:    return dut.pc_q;
      K_ZF:    return {7'b0, dut.zf_q};
      K_OF:    return {7'b0, dut.of_q};
      K_MEM:   return dut.mem.mem[idx];
      K_IR:    return dut.ir_q;
      default: return {6'b0, dut.state_q};
    endcase
  endfunction

  // Hold reset, clear memory and load prog at address 0.
  task automatic begin_load();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.mem.mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) dut.mem.mem[i] = prog[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset and take the IDLE->FETCH edge.
  task automatic start_run();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_instr();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [7:0] obs;
    int done = 0;
    prog = {};
    begin_load();
    for (int i = 0; i < 4; i++) expect_at(0, K_REG, i, 8'h00, "reset_reg");
    expect_at(0, K_PC, 0, 8'h00, "reset_pc");
    expect_at(0, K_ZF, 0, 8'h00, "reset_zf");
    expect_at(0, K_OF, 0, 8'h00, "reset_of");
    expect_at(0, K_ST, 0, 8'h00, "reset_state_idle");
    expect_at(1, K_PC, 0, 8'h00, "idle_edge_no_fetch");
    expect_at(1, K_ST, 0, 8'h01, "idle_to_fetch");
    expect_at(2, K_PC, 0, 8'h01, "first_fetch_pc");
    expect_at(2, K_ST, 0, 8'h02, "fetch_to_decode");
    rst = 1'b0;
    while (sb.size() > 0) begin
      if (sb[0].at == done) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_cmp++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
        end
      end else begin
        @(posedge clk);
        @(negedge clk);
        done++;
      end
    end
  endtask

  task automatic test_add_loop();
    exp_t e;
    logic [7:0] obs;
    int done = 0;
    prog = '{8'h90, 8'd30, 8'h94, 8'd30, 8'hF0, 8'd9, 8'h01, 8'hD0, 8'd4, 8'h60};
    begin_load();
    dut.mem.mem[30] = 8'd8;
    // 2 loads + 31 x (bio, add, buc) + taken bio + nop
    expect_at(2, K_REG, 0, 8'd8, "loop_r0_loaded");
    expect_at(97, K_PC, 0, 8'd10, "loop_pc_after_nop");
    expect_at(97, K_REG, 0, 8'h00, "loop_r0_wrapped");
    expect_at(97, K_REG, 1, 8'd8, "loop_r1");
    expect_at(97, K_OF, 0, 8'h01, "loop_of");
    expect_at(97, K_ZF, 0, 8'h01, "loop_zf");
    expect_at(97, K_IR, 0, 8'h60, "loop_last_ir_nop");
    start_run();
    while (sb.size() > 0) begin
      if (sb[0].at == done) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_cmp++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
        end
      end else begin
        step_instr();
        done++;
      end
    end
  endtask

  task automatic test_alu();
    exp_t e;
    logic [7:0] obs;
    int done = 0;
    // readi R0,F0; readi R1,3C; mov R2,R0; and R2,R1; mov R3,R0; or R3,R1;
    // not R2,R1; sub R1,R0; readi R3,10; mul R3,R3
    prog = '{8'hA0, 8'hF0, 8'hA4, 8'h3C, 8'h78, 8'h29, 8'h7C, 8'h4D,
             8'h39, 8'h14, 8'hAC, 8'h10, 8'h5F};
    begin_load();
    expect_at(4, K_REG, 2, 8'h30, "alu_and");
    expect_at(4, K_ZF, 0, 8'h00, "alu_and_zf");
    expect_at(6, K_REG, 3, 8'hFC, "alu_or");
    expect_at(7, K_REG, 2, 8'hC3, "alu_not");
    expect_at(7, K_OF, 0, 8'h00, "alu_not_of");
    expect_at(8, K_REG, 1, 8'h4C, "alu_sub");
    expect_at(8, K_OF, 0, 8'h01, "alu_sub_borrow");
    expect_at(8, K_ZF, 0, 8'h00, "alu_sub_zf");
    expect_at(10, K_REG, 3, 8'h00, "alu_mul_same_reg");
    expect_at(10, K_OF, 0, 8'h01, "alu_mul_of");
    expect_at(10, K_ZF, 0, 8'h01, "alu_mul_zf");
    start_run();
    while (sb.size() > 0) begin
      if (sb[0].at == done) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_cmp++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
        end
      end else begin
        step_instr();
        done++;
      end
    end
  endtask

  task automatic test_memory();
    exp_t e;
    logic [7:0] obs;
    int done = 0;
    // readi R2,55; write R2,80; readi R3,81; writei R2->[R3]; regid R0,[R3]; read R1,80
    prog = '{8'hA8, 8'h55, 8'hB8, 8'h80, 8'hAC, 8'h81, 8'hCB, 8'h83, 8'h94, 8'h80};
    begin_load();
    expect_at(1, K_MEM, 8'h80, 8'h00, "mem_before_write");
    expect_at(2, K_MEM, 8'h80, 8'h55, "mem_write");
    expect_at(4, K_MEM, 8'h81, 8'h55, "mem_writei");
    expect_at(4, K_PC, 0, 8'd7, "mem_writei_single_byte");
    expect_at(5, K_REG, 0, 8'h55, "mem_regid");
    expect_at(6, K_REG, 1, 8'h55, "mem_read");
    expect_at(6, K_PC, 0, 8'd10, "mem_pc");
    start_run();
    while (sb.size() > 0) begin
      if (sb[0].at == done) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_cmp++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
        end
      end else begin
        step_instr();
        done++;
      end
    end
  endtask

  task automatic test_branches();
    exp_t e;
    logic [7:0] obs;
    int done = 0;
    prog = '{8'hA0, 8'h01, 8'h10, 8'hF0, 8'h40, 8'hE0, 8'h20};
    begin_load();
    // at 0x20: readi R1,1; or R1,R1; biz 40; buc FE. At 0xFE/0xFF: nop, nop
    dut.mem.mem[8'h20] = 8'hA4;
    dut.mem.mem[8'h21] = 8'h01;
    dut.mem.mem[8'h22] = 8'h45;
    dut.mem.mem[8'h23] = 8'hE0;
    dut.mem.mem[8'h24] = 8'h40;
    dut.mem.mem[8'h25] = 8'hD0;
    dut.mem.mem[8'h26] = 8'hFE;
    dut.mem.mem[8'hFE] = 8'h60;
    dut.mem.mem[8'hFF] = 8'h60;
    expect_at(2, K_ZF, 0, 8'h01, "br_sub_self_zf");
    expect_at(2, K_OF, 0, 8'h00, "br_sub_self_of");
    expect_at(3, K_PC, 0, 8'h05, "br_bio_not_taken");
    expect_at(4, K_PC, 0, 8'h20, "br_biz_taken");
    expect_at(7, K_PC, 0, 8'h25, "br_biz_not_taken");
    expect_at(8, K_PC, 0, 8'hFE, "br_buc");
    expect_at(9, K_PC, 0, 8'hFF, "br_nop_fe");
    expect_at(10, K_PC, 0, 8'h00, "br_pc_wrap");
    start_run();
    while (sb.size() > 0) begin
      if (sb[0].at == done) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_cmp++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
        end
      end else begin
        step_instr();
        done++;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [7:0] obs;
    int done = 0;
    prog = '{8'hA8, 8'h77, 8'hB8, 8'h90};
    begin_load();
    start_run();
    step_instr();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    // write is now in EXEC; its memory write would land on the next edge
    expect_at(0, K_ST, 0, 8'h03, "ar_in_exec");
    expect_at(0, K_PC, 0, 8'h04, "ar_pc_before");
    expect_at(1, K_PC, 0, 8'h00, "ar_pc_cleared");
    expect_at(1, K_REG, 2, 8'h00, "ar_r2_cleared");
    expect_at(1, K_ST, 0, 8'h00, "ar_state_idle");
    expect_at(2, K_MEM, 8'h90, 8'h00, "ar_write_aborted");
    expect_at(2, K_MEM, 8'h02, 8'hB8, "ar_mem_kept");
    while (sb.size() > 0) begin
      if (sb[0].at == done) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_cmp++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
        end
      end else if (done == 0) begin
        #2 rst = 1'b1;
        #1;
        done++;
      end else begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        done++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_add_loop();
    test_alu();
    test_memory();
    test_branches();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
